uart_rx_buffer: RTL

//  Receive-side FIFO between the UART receiver and the consumer logic. Captures each byte

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_fifo_mem.sv | 38 +++
 rtl/uart_rx_buffer.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART defaults: byte width, receive FIFO depth and reset polarity.
// Constants only; no logic, no latency.
package uart_pkg;
  localparam int   DATA_W_DEF = 8;
  localparam int   ADDR_W_DEF = 3;
  localparam logic RST_ACTIVE = 1'b0;
endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port RAM with synchronous write and registered read of the next head address.
// One-cycle read latency; a same-cycle write to the read address is forwarded. No backpressure.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Forwarding lets a byte written into an empty FIFO be visible right after its write edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (i_rst == RST_ACTIVE) begin
      r_rd_data <= '0;
    end else if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
      r_rd_data <= i_wr_data;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/uart_rx_buffer.sv
// Receive FIFO between UART receiver and consumer; FWFT head, head valid the cycle after a write.
// No backpressure upstream: bytes arriving while full are dropped and flagged as overrun.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit DROP_BAD = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_rx_frame_err,
  input  logic              i_rd_req,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overrun,
  output logic              o_frame_err
);
  localparam int            DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;
  logic              r_frame_err;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_storable;
  logic              w_push;
  logic              w_lost;
  logic              w_bad;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_FULL);
  assign w_pop        = i_rd_req & ~w_empty;
  assign w_storable   = i_rx_done & ~(DROP_BAD & i_rx_frame_err);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_push       = w_storable & (~w_full | w_pop);
  assign w_lost       = w_storable & w_full & ~w_pop;
  assign w_bad        = i_rx_done & i_rx_frame_err;
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (i_rst == RST_ACTIVE) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overrun   <= w_lost | (r_overrun & ~i_clr_err);
      r_frame_err <= w_bad | (r_frame_err & ~i_clr_err);
    end
  end

  uart_fifo_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_rx_data),
    .i_rd_addr (w_rd_ptr_nxt),
    .o_rd_data (o_data_out)
  );

  assign o_data_valid = ~w_empty;
  assign o_empty      = w_empty;
  assign o_full       = w_full;
  assign o_count      = r_count;
  assign o_overrun    = r_overrun;
  assign o_frame_err  = r_frame_err;
endmodule
